avalon_slave_arbiter: RTL and testbench
=======================================

Name: avalon_slave_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares one 32-bit register slave (11-bit byte address) between a PCP-side and a host-side requester.
- Grants round-robin, forwards one transfer at a time, and completes it on slave waitrequest low.
- A watchdog aborts transfers the slave stalls, returning TIMEOUT_DATA so no master hangs.

Parameters:
- ADDR_WIDTH, 11, address width on all ports.
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, BUSY cycles with slave waitrequest high before abort; legal range 2..255.
- TIMEOUT_DATA, 32'hDEAD_BEEF, readdata returned on an aborted read.

Ports:
- iClk  in  1  clock
- nReset  in  1  asynchronous active-low reset
- m0_address  in  ADDR_WIDTH  master 0 address
- m0_byteenable  in  4  master 0 byteenable
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  32  master 0 write data
- m0_readdata  out  32  master 0 read data
- m0_waitrequest  out  1  master 0 stall
- m1_*  same seven ports for master 1
- avm_address  out  ADDR_WIDTH  to slave
- avm_byteenable  out  4  to slave
- avm_read  out  1  to slave
- avm_write  out  1  to slave
- avm_writedata  out  32  to slave
- avm_readdata  in  32  from slave
- avm_waitrequest  in  1  from slave
- oTimeout  out  1  one-cycle pulse on abort
- oTimeoutMaster  out  1  index of the aborted master; held until the next abort

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE, grant=0, last_grant=1 (so m0 wins the first tie), counter=0, oTimeout=0, oTimeoutMaster=0.
  - avm_read/avm_write=0.
- Requests and waitrequest:
  - req_n = mn_read | mn_write. If both are set, write wins and read is ignored.
  - mn_waitrequest = req_n, except on the completion cycle of master n. It equals req_n during reset too.
- FSM states are IDLE, BUSY and TOUT.
- IDLE:
  - avm_read/avm_write=0.
  - If only one req is set, that master is granted.
  - If both are set, grant = ~last_grant.
  - A grant moves the FSM to BUSY next cycle and clears the counter. With no req, stay in IDLE.
- BUSY:
  - avm_* is driven combinationally from the granted master.
  - avm_waitrequest=0: completion. Granted mn_waitrequest=0 this cycle and mn_readdata=avm_readdata. Then last_grant<=grant and go to IDLE.
  - avm_waitrequest=1: counter increments. When counter==TIMEOUT_CYCLES-1 and waitrequest is still 1, go to TOUT.
  - Granted master drops req mid-transfer (protocol violation): go to IDLE with no completion and last_grant unchanged.
- TOUT (one cycle):
  - avm_read/avm_write=0 (transfer abandoned).
  - Granted mn_waitrequest=0 and mn_readdata=TIMEOUT_DATA; an aborted write is simply acknowledged.
  - oTimeout=1 and oTimeoutMaster=grant. Then last_grant<=grant and go to IDLE.
- Readdata rules:
  - Non-granted master always sees waitrequest=req and readdata=0.
  - Granted master's readdata is 0 outside its completion cycle.
- Latency: minimum 2 cycles per transfer (grant cycle + completion cycle). An aborted transfer takes 1 + TIMEOUT_CYCLES + 1 cycles.
- Back-to-back: after a completion the FSM always passes through IDLE, so alternating masters each get every other slot, giving a fairness bound of one transfer.
- Reset mid-transfer: immediate return to IDLE with avm_read/write low. The in-flight transfer is lost and no completion is signalled.
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits. It saturates and never wraps.

Decomposition:
- Package avalon_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, TOUT=2'd2);
  - the default TIMEOUT_DATA constant;
  - a byteenable-width function.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (req[1:0], last_grant, returns grant_valid and grant). Everything else stays in the top.

Test Plan:
- Single read: m0 reads address 0x004 and the slave drops waitrequest on its second BUSY cycle with readdata 0x1234_5678 -> m0_readdata=0x1234_5678 with m0_waitrequest low for exactly one cycle, 3 cycles after request.
- Contention: m0 and m1 write continuously after reset -> slave sees m0, m1, m0, m1; oTimeout stays 0.
- Timeout: slave holds waitrequest high and m1 reads -> after 16 BUSY cycles there is one TOUT cycle with m1_readdata=0xDEAD_BEEF, oTimeout=1 and oTimeoutMaster=1; avm_read is low in TOUT.
- Read+write collision: m0_read=m0_write=1 with writedata 0xA5A5_A5A5 -> avm_write=1, avm_read=0, avm_writedata=0xA5A5_A5A5.
- Reset mid-transfer: nReset pulsed low during BUSY -> avm_read/avm_write drop in the same cycle (async), state is IDLE, and there is no completion pulse to either master.
- Request drop: m1 deasserts read in BUSY -> FSM returns to IDLE, and a following m0+m1 tie still grants m1 (last_grant unchanged).

Source files
------------

// File: rtl/avalon_slave_arbiter_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
// Holds the FSM encoding, the abort readdata and a width helper.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/avalon_slave_arbiter_if.sv
// One Avalon-MM port: the requester drives through master,
// the responder (or arbiter front end) uses slave.
interface avalon_slave_arbiter_if
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/avalon_slave_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright,
// a tie goes to the master that was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    // Resolve the winner among the pending requests.
    always_comb begin
        grant_valid = |req;
        grant       = 1'b0;
        unique case (1'b1)
            (req == 2'b11): grant = ~last_grant;
            (req == 2'b10): grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/avalon_slave_arbiter.sv
// Shares one Avalon-MM register slave between two masters,
// one transfer at a time, with a stall watchdog.
module avalon_slave_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
    input  logic                  iClk,
    input  logic                  nReset,
    avalon_slave_arbiter_if.slave  m0,
    avalon_slave_arbiter_if.slave  m1,
    avalon_slave_arbiter_if.master avm,
    output logic                  oTimeout,
    output logic                  oTimeoutMaster
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       to_master_q, to_master_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] req;
    logic       pick_valid;
    logic       pick;
    logic       req_g;
    logic       rd_g;
    logic       wr_g;
    logic       done;
    logic       ack;
    logic [DATA_WIDTH-1:0] ack_data;
    logic [ADDR_WIDTH-1:0] addr_g;

    assign req   = {m1.read | m1.write, m0.read | m0.write};
    assign req_g = grant_q ? req[1] : req[0];
    assign rd_g  = grant_q ? m1.read : m0.read;
    assign wr_g  = grant_q ? m1.write : m0.write;

    rr_pick2 u_pick (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant       (pick)
    );

    // State, grant bookkeeping and watchdog counter.
    always_ff @(posedge iClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            to_master_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            to_master_q  <= to_master_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next state: grant, complete, abort or drop the transfer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        to_master_d  = to_master_q;
        cnt_d        = cnt_q;
        done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_g) begin
                    state_d = IDLE;
                end else if (!avm.waitrequest) begin
                    done         = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        to_master_d = grant_q;
                        state_d     = TOUT;
                    end
                end
            end
            TOUT: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Route the granted master to the slave and acknowledge it.
    always_comb begin
        addr_g         = grant_q ? m1.address : m0.address;
        avm.address    = addr_g;
        avm.byteenable = grant_q ? m1.byteenable : m0.byteenable;
        avm.writedata  = grant_q ? m1.writedata : m0.writedata;
        avm.read       = 1'b0;
        avm.write      = 1'b0;
        if (state_q == BUSY) begin
            avm.write = wr_g;
            avm.read  = rd_g & ~wr_g;
        end
        ack      = done | (state_q == TOUT);
        ack_data = (state_q == TOUT) ? TIMEOUT_DATA : avm.readdata;
        m0.waitrequest = req[0];
        m1.waitrequest = req[1];
        m0.readdata    = '0;
        m1.readdata    = '0;
        if (ack && !grant_q) begin
            m0.waitrequest = 1'b0;
            m0.readdata    = ack_data;
        end
        if (ack && grant_q) begin
            m1.waitrequest = 1'b0;
            m1.readdata    = ack_data;
        end
    end

    assign oTimeout       = (state_q == TOUT);
    assign oTimeoutMaster = to_master_q;

endmodule

// File: tb/tb_avalon_slave_arbiter.sv
// Bench for avalon_slave_arbiter: directed transfers and a
// queued expectation of every completion seen on the masters.
module tb_avalon_slave_arbiter;
    import avalon_arb_pkg::*;

    typedef struct {
        logic        mst;
        logic        wr;
        logic        tout;
        logic [3:0]  be;
        logic [10:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [10:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        iClk = 1'b0;
    logic        nReset;
    logic        oTimeout;
    logic        oTimeoutMaster;
    int          total = 0;
    int          bad = 0;
    int          slv_wait = 0;
    int          busy_cnt = 0;
    logic [31:0] slv_rdata = '0;
    exp_t        exp_q[$];
    cmd_t        cmd0_q[$];
    cmd_t        cmd1_q[$];
    bit          ack0_s, ack1_s;
    bit          busy0, busy1, drv_en;
    int          lat;

    avalon_slave_arbiter_if m0_if ();
    avalon_slave_arbiter_if m1_if ();
    avalon_slave_arbiter_if avm_if ();

    avalon_slave_arbiter dut (
        .iClk           (iClk),
        .nReset         (nReset),
        .m0             (m0_if),
        .m1             (m1_if),
        .avm            (avm_if),
        .oTimeout       (oTimeout),
        .oTimeoutMaster (oTimeoutMaster)
    );

    always #5 iClk = ~iClk;

    // Slave model: stalls slv_wait cycles of each access.
    always @(posedge iClk)
        busy_cnt <= (avm_if.read || avm_if.write) ? busy_cnt + 1 : 0;

    assign avm_if.waitrequest = (busy_cnt < slv_wait);
    assign avm_if.readdata = slv_rdata ^ {21'd0, avm_if.address};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic set_master(input bit mst, input bit rd, input bit wr,
                              input logic [3:0] be, input logic [10:0] a,
                              input logic [31:0] d);
        if (mst) begin
            m1_if.read = rd; m1_if.write = wr; m1_if.byteenable = be;
            m1_if.address = a; m1_if.writedata = d;
        end else begin
            m0_if.read = rd; m0_if.write = wr; m0_if.byteenable = be;
            m0_if.address = a; m0_if.writedata = d;
        end
    endtask

    task automatic push_exp(input bit mst, input bit wr, input bit tout,
                            input logic [3:0] be, input logic [10:0] a,
                            input logic [31:0] d);
        exp_t e;
        e.mst = mst; e.wr = wr; e.tout = tout;
        e.be = be; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input bit mst, input bit rd, input bit wr,
                            input logic [3:0] be, input logic [10:0] a,
                            input logic [31:0] d);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.be = be; c.addr = a; c.wdata = d;
        if (mst) cmd1_q.push_back(c);
        else cmd0_q.push_back(c);
    endtask

    task automatic drive_step();
        cmd_t c;
        if (drv_en) begin
            if (!busy0 || ack0_s) begin
                if (cmd0_q.size() > 0) begin
                    c = cmd0_q.pop_front();
                    set_master(1'b0, c.rd, c.wr, c.be, c.addr, c.wdata);
                    busy0 = 1'b1;
                end else begin
                    set_master(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
                    busy0 = 1'b0;
                end
            end
            if (!busy1 || ack1_s) begin
                if (cmd1_q.size() > 0) begin
                    c = cmd1_q.pop_front();
                    set_master(1'b1, c.rd, c.wr, c.be, c.addr, c.wdata);
                    busy1 = 1'b1;
                end else begin
                    set_master(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
                    busy1 = 1'b0;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        r0, r1;
        logic [31:0] rdv;
        r0 = m0_if.read | m0_if.write;
        r1 = m1_if.read | m1_if.write;
        ack0_s = r0 && !m0_if.waitrequest;
        ack1_s = r1 && !m1_if.waitrequest;
        if (!ack0_s) begin
            chk("wait0", 32'(m0_if.waitrequest), 32'(r0));
            chk("rdata0_idle", m0_if.readdata, 32'd0);
        end
        if (!ack1_s) begin
            chk("wait1", 32'(m1_if.waitrequest), 32'(r1));
            chk("rdata1_idle", m1_if.readdata, 32'd0);
        end
        if (ack0_s || ack1_s) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 32'({ack1_s, ack0_s}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_mst", 32'({ack1_s, ack0_s}),
                    32'(e.mst ? 2'b10 : 2'b01));
                chk("ack_tout", 32'(oTimeout), 32'(e.tout));
                rdv = e.mst ? m1_if.readdata : m0_if.readdata;
                if (e.tout) begin
                    chk("tout_mst", 32'(oTimeoutMaster), 32'(e.mst));
                    chk("tout_data", rdv, TIMEOUT_DATA_DEF);
                    chk("tout_avm", 32'({avm_if.read, avm_if.write}), 32'd0);
                end else begin
                    chk("avm_addr", 32'(avm_if.address), 32'(e.addr));
                    chk("avm_be", 32'(avm_if.byteenable), 32'(e.be));
                    chk("avm_wr", 32'(avm_if.write), 32'(e.wr));
                    chk("avm_rd", 32'(avm_if.read), 32'(!e.wr));
                    if (e.wr) chk("avm_wdata", avm_if.writedata, e.data);
                    else chk("rdata", rdv, e.data);
                end
            end
        end else begin
            chk("tout_quiet", 32'(oTimeout), 32'd0);
        end
    endtask

    task automatic next_cycle();
        @(posedge iClk);
        #1;
        drive_step();
    endtask

    task automatic sample();
        @(negedge iClk);
        monitor();
    endtask

    task automatic cyc();
        next_cycle();
        sample();
    endtask

    task automatic xfer(input bit mst, input bit rd, input bit wr,
                        input logic [3:0] be, input logic [10:0] a,
                        input logic [31:0] d, input logic [31:0] erd,
                        input bit tout, output int l);
        push_exp(mst, wr, tout, be, a, wr ? d : erd);
        next_cycle();
        set_master(mst, rd, wr, be, a, d);
        l = -1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) next_cycle();
            sample();
            if (mst ? ack1_s : ack0_s) begin
                l = i;
                break;
            end
        end
        next_cycle();
        set_master(mst, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
        sample();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (exp_q.size() == 0 && !busy0 && !busy1) break;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_en = 1'b0;
        nReset = 1'b0;
        set_master(1'b0, 1'b1, 1'b0, 4'h0, 11'h0, 32'h0);
        set_master(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
        sample();
        chk("rst_wait0", 32'(m0_if.waitrequest), 32'd1);
        chk("rst_avm", 32'({avm_if.read, avm_if.write}), 32'd0);
        chk("rst_tout", 32'(oTimeout), 32'd0);
        chk("rst_tmst", 32'(oTimeoutMaster), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_last", 32'(dut.last_grant_q), 32'd1);
        chk("rst_grant", 32'(dut.grant_q), 32'd0);
        set_master(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
        next_cycle();
        nReset = 1'b1;
        sample();
        cyc();

        slv_wait = 1;
        slv_rdata = 32'h1234_567C;
        xfer(1'b0, 1'b1, 1'b0, 4'hF, 11'h004, 32'h0,
             32'h1234_5678, 1'b0, lat);
        chk("rd_lat", 32'(lat), 32'd2);

        slv_wait = 0;
        xfer(1'b0, 1'b1, 1'b1, 4'hF, 11'h008, 32'hA5A5_A5A5,
             32'h0, 1'b0, lat);
        chk("col_lat", 32'(lat), 32'd1);

        slv_wait = 1000;
        xfer(1'b1, 1'b1, 1'b0, 4'hF, 11'h030, 32'h0,
             32'h0, 1'b1, lat);
        chk("tout_lat", 32'(lat), 32'd17);
        cyc();
        cyc();
        chk("tout_hold", 32'(oTimeoutMaster), 32'd1);

        next_cycle();
        set_master(1'b0, 1'b1, 1'b0, 4'hF, 11'h050, 32'h0);
        sample();
        cyc();
        cyc();
        chk("mid_busy", 32'(dut.state_q), 32'(BUSY));
        chk("mid_avm_rd", 32'(avm_if.read), 32'd1);
        @(posedge iClk);
        #3;
        nReset = 1'b0;
        #1;
        chk("rst_avm_drop", 32'({avm_if.read, avm_if.write}), 32'd0);
        chk("rst_idle", 32'(dut.state_q), 32'(IDLE));
        chk("rst_tmst_clr", 32'(oTimeoutMaster), 32'd0);
        set_master(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
        sample();
        next_cycle();
        nReset = 1'b1;
        sample();
        cyc();

        slv_wait = 1;
        for (int k = 0; k < 4; k++) begin
            push_cmd(1'b0, 1'b0, 1'b1, 4'hF, 11'(12'h010 + 4 * k),
                     32'h0000_1000 + k);
            push_cmd(1'b1, 1'b0, 1'b1, 4'h3, 11'(12'h020 + 4 * k),
                     32'h2000_0000 + k);
            push_exp(1'b0, 1'b1, 1'b0, 4'hF, 11'(12'h010 + 4 * k),
                     32'h0000_1000 + k);
            push_exp(1'b1, 1'b1, 1'b0, 4'h3, 11'(12'h020 + 4 * k),
                     32'h2000_0000 + k);
        end
        drv_en = 1'b1;
        drain("cont_drain");
        drv_en = 1'b0;

        slv_wait = 0;
        slv_rdata = 32'hCAFE_0000;
        xfer(1'b0, 1'b1, 1'b0, 4'h1, 11'h040, 32'h0,
             32'hCAFE_0040, 1'b0, lat);
        chk("pre_lat", 32'(lat), 32'd1);

        slv_wait = 1000;
        next_cycle();
        set_master(1'b1, 1'b1, 1'b0, 4'hF, 11'h060, 32'h0);
        sample();
        cyc();
        chk("drop_busy", 32'(dut.state_q), 32'(BUSY));
        next_cycle();
        set_master(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
        sample();
        cyc();
        chk("drop_idle", 32'(dut.state_q), 32'(IDLE));
        chk("drop_last", 32'(dut.last_grant_q), 32'd0);

        slv_wait = 1;
        push_cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h044, 32'h0);
        push_cmd(1'b1, 1'b1, 1'b0, 4'hF, 11'h048, 32'h0);
        push_exp(1'b1, 1'b0, 1'b0, 4'hF, 11'h048, 32'hCAFE_0048);
        push_exp(1'b0, 1'b0, 1'b0, 4'hF, 11'h044, 32'hCAFE_0044);
        drv_en = 1'b1;
        drain("tie_drain");
        drv_en = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
